// File: rtl/ysyx_24100005_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_ifu_pkg
// Shared definitions for the instruction-fetch controller of the multicycle
// NPC: fetch FSM state encoding, reset PC, PC increment and a NOP word used
// as filler on idle response buses.
// ---------------------------------------------------------------------------
package ysyx_24100005_ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  // Fixed encodings keep the state register readable in legacy waveform
  // viewers and netlists.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  // Instruction fetch is word-granular; any set low bit is a misaligned PC.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24100005_ifu_ctrl_pc_gen.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_pc_gen
// Fetch PC register with next-PC selection: redirect target, sequential
// PC+4 (wrapping modulo 2^ADDR_W) or hold.
//
// Ports
//   clk           in   clock
//   rst           in   synchronous active-low reset (PC <= RESET_PC)
//   redirect_i    in   load redirect_pc_i (wins over advance_i)
//   redirect_pc_i in   redirect target
//   advance_i     in   step PC by PC_STEP
//   pc_o          out  current fetch PC
// ---------------------------------------------------------------------------
module ysyx_24100005_pc_gen
  import ysyx_24100005_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (advance_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_24100005_ifu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_ifu_ctrl
// Instruction-fetch controller: owns the fetch PC, keeps at most one request
// outstanding to instruction memory, holds each fetched word until decode
// takes it, and applies execute-stage redirects, squashing wrong-path fetches
// with a kill flag.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   imem_req_valid/ready/addr request channel (address stable until ready)
//   imem_rsp_valid/data/err   response channel (sampled only while waiting)
//   redirect_valid/pc         redirect from execute (ignored in BOOT)
//   inst_valid/ready          decode handshake
//   inst, inst_pc             held instruction and its PC
//   fetch_fault               qualifies inst_valid: access error or bad PC
//
// Optional build macro YSYX_24100005_IFU_PERF_EN adds perf_fetch_cnt
// (committed decode handshakes) and perf_wait_cnt (memory stall cycles).
// ---------------------------------------------------------------------------
module ysyx_24100005_ifu_ctrl
  import ysyx_24100005_ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_fault
`ifdef YSYX_24100005_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_wait_cnt
`endif
);

  ifu_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic              req_pend_q, req_pend_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] pc;
  logic              redirect_en;
  logic              pc_aligned;
  logic              req_fire;
  logic              dec_fire;
  logic              advance;

  assign redirect_en = redirect_valid && (state_q != ST_BOOT);
  assign pc_aligned  = !pc_misaligned(pc[1:0]);

  // Once a request has been shown to memory it is frozen in req_addr_q, so a
  // redirect that moves the PC cannot disturb the pending address.
  assign imem_req_valid = (state_q == ST_REQ) && (req_pend_q || pc_aligned);
  assign imem_req_addr  = req_pend_q ? req_addr_q : pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A decode handshake coincident with a redirect is void and does not step.
  assign dec_fire = inst_valid_q && inst_ready;
  assign advance  = dec_fire && !redirect_en;

  ysyx_24100005_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_en),
    .redirect_pc_i (redirect_pc),
    .advance_i     (advance),
    .pc_o          (pc)
  );

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    req_pend_d   = req_pend_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = fault_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (imem_req_valid) begin
          // A redirect after the request is visible cannot retract it; the
          // response is squashed later instead.
          kill_d = kill_q || redirect_en;
          if (req_fire) begin
            state_d    = ST_WAIT;
            req_pend_d = 1'b0;
          end else begin
            req_pend_d = 1'b1;
            req_addr_d = imem_req_addr;
          end
        end else if (!redirect_en) begin
          // Misaligned PC: never reaches memory, deliver a fault instead.
          // A simultaneous redirect simply retries from the new PC.
          state_d      = ST_HOLD;
          inst_d       = 32'h0;
          inst_pc_d    = pc;
          fault_d      = 1'b1;
          inst_valid_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_en) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            // With no redirect since the request, pc is still its address.
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc;
            fault_d      = imem_rsp_err;
            inst_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end else if (redirect_en) begin
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect_en || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      kill_q       <= 1'b0;
      req_pend_q   <= 1'b0;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      req_pend_q   <= req_pend_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
    end
  end

  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_fault = fault_q;

`ifdef YSYX_24100005_IFU_PERF_EN
  logic [63:0] perf_fetch_q;
  logic [63:0] perf_wait_q;
  logic        stall;

  assign stall = ((state_q == ST_REQ)  && !imem_req_ready) ||
                 ((state_q == ST_WAIT) && !imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= 64'd0;
      perf_wait_q  <= 64'd0;
    end else begin
      if (advance) perf_fetch_q <= perf_fetch_q + 64'd1;
      if (stall)   perf_wait_q  <= perf_wait_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule
